// File: rtl/rgb_to_gray_stream.sv
// Streaming RGB-to-gray converter: two-stage valid/ready pipeline, LEGACY or LUMA weighting per pixel.
// Optional per-frame statistics counters (pix_cnt, sat_cnt) compiled in with RGB2GRAY_STATS_EN.
module rgb_to_gray_stream #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3*IN_W-1:0]   in_rgb,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sof,
  input  logic                in_mode,
  output logic [OUT_W-1:0]    out_gray,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sof,
  output logic [23:0]         pix_cnt,
  output logic [15:0]         sat_cnt
);

  localparam int SUM_W   = IN_W + 8;
  localparam int LUMA_SH = 8 + IN_W - OUT_W;
  localparam logic [SUM_W-1:0] K_R      = SUM_W'(77);
  localparam logic [SUM_W-1:0] K_G      = SUM_W'(150);
  localparam logic [SUM_W-1:0] K_B      = SUM_W'(29);
  localparam logic [SUM_W-1:0] K_THREE  = SUM_W'(3);
  localparam logic [SUM_W-1:0] GRAY_MAX = {{(SUM_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic             s1_valid_r;
  logic [SUM_W-1:0] s1_sum_r;
  logic             s1_mode_r;
  logic             s1_sof_r;
  logic             s2_valid_r;
  logic [OUT_W-1:0] s2_gray_r;
  logic             s2_sof_r;

  logic             s2_adv_s;
  logic             s1_adv_s;
  logic             in_fire_s;
  logic [SUM_W-1:0] chan_r_s;
  logic [SUM_W-1:0] chan_g_s;
  logic [SUM_W-1:0] chan_b_s;
  logic [SUM_W-1:0] sum_s;
  logic [SUM_W-1:0] t_s;
  logic             sat_s;
  logic [OUT_W-1:0] gray_s;

  // Pipeline handshake: each stage moves when empty or when the stage after it moves.
  always_comb begin
    s2_adv_s  = !s2_valid_r || out_ready;
    s1_adv_s  = !s1_valid_r || s2_adv_s;
    in_ready  = s1_adv_s && !rst;
    in_fire_s = in_valid && in_ready;
  end

  // Stage-1 arithmetic: plain channel sum (LEGACY) or weighted sum (LUMA), full width.
  always_comb begin
    chan_r_s = {{8{1'b0}}, in_rgb[3*IN_W-1:2*IN_W]};
    chan_g_s = {{8{1'b0}}, in_rgb[2*IN_W-1:IN_W]};
    chan_b_s = {{8{1'b0}}, in_rgb[IN_W-1:0]};
    sum_s    = {SUM_W{1'b0}};
    if (in_mode) begin
      sum_s = chan_r_s * K_R + chan_g_s * K_G + chan_b_s * K_B;
    end else begin
      sum_s = chan_r_s + chan_g_s + chan_b_s;
    end
  end

  // Stage-2 arithmetic: scale the captured sum, then clamp to the output range.
  always_comb begin
    t_s = {SUM_W{1'b0}};
    if (s1_mode_r) begin
      t_s = s1_sum_r >> LUMA_SH;
    end else begin
      t_s = ((s1_sum_r >> 3'd3) * K_THREE) >> 1'b1;
    end
    sat_s  = (t_s > GRAY_MAX);
    gray_s = sat_s ? {OUT_W{1'b1}} : t_s[OUT_W-1:0];
  end

  // Stage-1 register: sum, mode and sof of the accepted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_sum_r   <= {SUM_W{1'b0}};
      s1_mode_r  <= 1'b0;
      s1_sof_r   <= 1'b0;
    end else if (s1_adv_s) begin
      s1_valid_r <= in_fire_s;
      if (in_fire_s) begin
        s1_sum_r  <= sum_s;
        s1_mode_r <= in_mode;
        s1_sof_r  <= in_sof;
      end
    end
  end

  // Stage-2 register: drives the output port directly so it holds during stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_gray_r  <= {OUT_W{1'b0}};
      s2_sof_r   <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_gray_r <= gray_s;
        s2_sof_r  <= s1_sof_r;
      end
    end
  end

  assign out_valid = s2_valid_r;
  assign out_gray  = s2_gray_r;
  assign out_sof   = s2_sof_r;

`ifdef RGB2GRAY_STATS_EN
  logic        s2_sat_r;
  logic        out_fire_s;
  logic [23:0] pix_cnt_r;
  logic [15:0] sat_cnt_r;

  assign out_fire_s = s2_valid_r && out_ready;

  // Saturation flag travels alongside the stage-2 gray value.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_sat_r <= 1'b0;
    end else if (s2_adv_s && s1_valid_r) begin
      s2_sat_r <= sat_s;
    end
  end

  // Frame statistics: restart on an SOF pixel, otherwise count up and stick at the maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt_r <= 24'd0;
      sat_cnt_r <= 16'd0;
    end else if (out_fire_s) begin
      if (s2_sof_r) begin
        pix_cnt_r <= 24'd1;
        sat_cnt_r <= {15'd0, s2_sat_r};
      end else begin
        pix_cnt_r <= (pix_cnt_r == 24'hFF_FFFF) ? pix_cnt_r : pix_cnt_r + 24'd1;
        sat_cnt_r <= (sat_cnt_r == 16'hFFFF || !s2_sat_r) ? sat_cnt_r : sat_cnt_r + 16'd1;
      end
    end
  end

  assign pix_cnt = pix_cnt_r;
  assign sat_cnt = sat_cnt_r;
`else
  assign pix_cnt = 24'd0;
  assign sat_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_rgb_to_gray_stream.sv
// Randomized self-checking bench for rgb_to_gray_stream (IN_W=10, OUT_W=8) against a queue-based
// reference model; counter expectations follow whether RGB2GRAY_STATS_EN is defined.
module tb_rgb_to_gray_stream;

  localparam int IN_W  = 10;
  localparam int OUT_W = 8;
`ifdef RGB2GRAY_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [3*IN_W-1:0] in_rgb;
  logic              in_valid;
  logic              in_ready;
  logic              in_sof;
  logic              in_mode;
  logic [OUT_W-1:0]  out_gray;
  logic              out_valid;
  logic              out_ready;
  logic              out_sof;
  logic [23:0]       pix_cnt;
  logic [15:0]       sat_cnt;

  rgb_to_gray_stream #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst),
    .in_rgb(in_rgb), .in_valid(in_valid), .in_ready(in_ready),
    .in_sof(in_sof), .in_mode(in_mode),
    .out_gray(out_gray), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .pix_cnt(pix_cnt), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] gray;
    logic       sof;
    logic       sat;
    int         acc;
  } pix_t;

  int   errors = 0;
  int   checks = 0;
  pix_t exp_q[$];
  int   cyc = 0;
  int   exp_pix = 0;
  int   exp_sat = 0;
  int   n_out = 0;

  // Reference conversion straight from the arithmetic rules, using plain integers.
  function automatic pix_t ref_pixel(logic [29:0] rgb, logic mode, logic sof);
    pix_t p;
    int r, g, b, t;
    r = int'(rgb[29:20]);
    g = int'(rgb[19:10]);
    b = int'(rgb[9:0]);
    if (!mode) t = (((r + g + b) / 8) * 3) / 2;
    else       t = (77 * r + 150 * g + 29 * b) / 1024;
    p.sat  = (t > 255);
    p.gray = p.sat ? 8'd255 : t[7:0];
    p.sof  = sof;
    p.acc  = 0;
    return p;
  endfunction

  task automatic drive(input logic v, input logic [29:0] rgb, input logic sof,
                       input logic mode, input logic rdy);
    in_valid  = v;
    in_rgb    = rgb;
    in_sof    = sof;
    in_mode   = mode;
    out_ready = rdy;
    #1;
  endtask

  // Advance one clock and move the model by the transfers that happen on that edge.
  task automatic tick();
    logic inf, outf;
    pix_t p, h;
    inf  = in_valid && in_ready;
    outf = out_valid && out_ready;
    p    = ref_pixel(in_rgb, in_mode, in_sof);
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_pix = 0;
      exp_sat = 0;
    end else begin
      if (outf && exp_q.size() > 0) begin
        h = exp_q.pop_front();
        n_out++;
        if (h.sof) begin
          exp_pix = 1;
          exp_sat = h.sat ? 1 : 0;
        end else begin
          if (exp_pix < 16777215) exp_pix++;
          if (h.sat && exp_sat < 65535) exp_sat++;
        end
      end
      if (inf) begin
        p.acc = cyc;
        exp_q.push_back(p);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  function automatic logic [29:0] rand_rgb();
    logic [29:0] v;
    v = 30'($urandom);
    if ($urandom_range(0, 7) == 0) v = 30'h3FFF_FFFF;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rand_rgb(), 1'b1, 1'b0, 1'b1);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_in_ready cycle %0d: got %b want 0", i, in_ready);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || out_gray !== 8'd0 || out_sof !== 1'b0 ||
        pix_cnt !== 24'd0 || sat_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b gray=%0d sof=%b pix=%0d sat=%0d want all 0",
               out_valid, out_gray, out_sof, pix_cnt, sat_cnt);
    end
    rst = 1'b0;
    drive(1'b0, 30'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [29:0] t_rgb  [4] = '{{10'd100, 10'd100, 10'd100}, 30'h3FFF_FFFF,
                                30'h3FFF_FFFF, {10'd400, 10'd0, 10'd0}};
    logic        t_mode [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0]  t_gray [4] = '{8'd55, 8'd255, 8'd255, 8'd30};
    logic [15:0] t_sat  [4] = '{16'd0, 16'd1, 16'd1, 16'd1};
    rst = 1'b1;
    drive(1'b0, 30'd0, 1'b0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, t_rgb[i], 1'b0, t_mode[i], 1'b1);
      tick();
      drive(1'b0, 30'd0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_early_valid[%0d]: got %b want 0", i, out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_gray !== t_gray[i]) begin
        errors++;
        $display("FAIL directed_gray[%0d]: valid=%b gray=%0d want valid=1 gray=%0d",
                 i, out_valid, out_gray, t_gray[i]);
      end
      tick();
      checks++;
      if (pix_cnt !== (STATS ? 24'(i + 1) : 24'd0) || sat_cnt !== (STATS ? t_sat[i] : 16'd0)) begin
        errors++;
        $display("FAIL directed_counters[%0d]: pix=%0d sat=%0d want pix=%0d sat=%0d", i,
                 pix_cnt, sat_cnt, STATS ? i + 1 : 0, STATS ? t_sat[i] : 16'd0);
      end
    end
  endtask

  task automatic test_random_stream();
    logic exp_v, rdy;
    for (int k = 0; k < 400; k++) begin
      rdy = ($urandom_range(0, 3) != 0);
      drive(1'($urandom), rand_rgb(), ($urandom_range(0, 15) == 0), 1'($urandom), rdy);
      checks++;
      if (in_ready !== !(exp_q.size() == 2 && !rdy)) begin
        errors++;
        $display("FAIL rand_in_ready cyc %0d: got %b occ=%0d rdy=%b", cyc, in_ready, exp_q.size(), rdy);
      end
      tick();
      exp_v = (exp_q.size() > 0) && (cyc - exp_q[0].acc >= 2);
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL rand_out_valid cyc %0d: got %b want %b", cyc, out_valid, exp_v);
      end else if (exp_v) begin
        checks++;
        if (out_gray !== exp_q[0].gray || out_sof !== exp_q[0].sof) begin
          errors++;
          $display("FAIL rand_data cyc %0d: gray=%0d sof=%b want gray=%0d sof=%b",
                   cyc, out_gray, out_sof, exp_q[0].gray, exp_q[0].sof);
        end
      end
      checks++;
      if (pix_cnt !== (STATS ? 24'(exp_pix) : 24'd0) || sat_cnt !== (STATS ? 16'(exp_sat) : 16'd0)) begin
        errors++;
        $display("FAIL rand_counters cyc %0d: pix=%0d sat=%0d want pix=%0d sat=%0d",
                 cyc, pix_cnt, sat_cnt, STATS ? exp_pix : 0, STATS ? exp_sat : 0);
      end
    end
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      drive(1'b0, 30'd0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: %0d pixels still expected", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int   sent, out0;
    logic rdy, exp_v;
    sent = 0;
    out0 = n_out;
    for (int k = 0; k < 60 && !(sent == 8 && exp_q.size() == 0); k++) begin
      rdy = (k % 4 == 0) || (k % 4 == 3);
      drive(sent < 8, rand_rgb(), (sent == 0), 1'(sent % 2), rdy);
      checks++;
      if (in_ready !== !(exp_q.size() == 2 && !rdy)) begin
        errors++;
        $display("FAIL bp_in_ready k=%0d: got %b occ=%0d rdy=%b", k, in_ready, exp_q.size(), rdy);
      end
      if (in_valid && in_ready) sent++;
      tick();
      exp_v = (exp_q.size() > 0) && (cyc - exp_q[0].acc >= 2);
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL bp_out_valid k=%0d: got %b want %b", k, out_valid, exp_v);
      end else if (exp_v) begin
        checks++;
        if (out_gray !== exp_q[0].gray || out_sof !== exp_q[0].sof) begin
          errors++;
          $display("FAIL bp_data k=%0d: gray=%0d sof=%b want gray=%0d sof=%b",
                   k, out_gray, out_sof, exp_q[0].gray, exp_q[0].sof);
        end
      end
    end
    checks++;
    if (n_out - out0 != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_count: outputs=%0d pending=%0d want 8 and 0", n_out - out0, exp_q.size());
    end
  endtask

  task automatic test_frame_counters();
    int sent, out0;
    bit seen5;
    sent  = 0;
    out0  = n_out;
    seen5 = 1'b0;
    for (int k = 0; k < 20 && n_out - out0 < 6; k++) begin
      drive(sent < 6, rand_rgb(), (sent == 0 || sent == 5), 1'($urandom), 1'b1);
      if (in_valid && in_ready) sent++;
      tick();
      if (n_out - out0 == 5 && !seen5) begin
        seen5 = 1'b1;
        checks++;
        if (pix_cnt !== (STATS ? 24'd5 : 24'd0)) begin
          errors++;
          $display("FAIL frame_pix5: got %0d want %0d", pix_cnt, STATS ? 5 : 0);
        end
      end
    end
    checks++;
    if (pix_cnt !== (STATS ? 24'd1 : 24'd0) || sat_cnt !== (STATS ? 16'(exp_sat) : 16'd0) || !seen5) begin
      errors++;
      $display("FAIL frame_restart: pix=%0d sat=%0d seen5=%b want pix=%0d sat=%0d",
               pix_cnt, sat_cnt, seen5, STATS ? 1 : 0, STATS ? exp_sat : 0);
    end
  endtask

  task automatic test_reset_midstream();
    logic [29:0] rgb;
    pix_t        p;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, rand_rgb(), 1'b0, 1'b0, 1'b0);
      tick();
    end
    rst = 1'b1;
    drive(1'b1, rand_rgb(), 1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_valid: got %b want 0", out_valid);
    end
    rst = 1'b0;
    rgb = {10'd512, 10'd256, 10'd128};
    p   = ref_pixel(rgb, 1'b1, 1'b1);
    drive(1'b1, rgb, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 30'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_stale: got valid=%b want 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_gray !== p.gray || out_sof !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_first: valid=%b gray=%0d sof=%b want 1 %0d 1",
               out_valid, out_gray, out_sof, p.gray);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_rgb    = 30'd0;
    in_sof    = 1'b0;
    in_mode   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random_stream();
    test_back_to_back();
    test_frame_counters();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgb_to_gray_stream.md
RGB_TO_GRAY_STREAM -- requirements
Module: rgb_to_gray_stream

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock), then rst input 1 (synchronous, active-high reset).
REQ-002 The block SHALL have parameter IN_W, default 10: per-channel input width, range 4..16.
REQ-003 The block SHALL have parameter OUT_W, default 8: gray output width, range 2..IN_W.
REQ-004 The block SHALL have port in_rgb, input, 3*IN_W: [3*IN_W-1:2*IN_W]=R, [2*IN_W-1:IN_W]=G, [IN_W-1:0]=B.
REQ-005 The block SHALL have port in_valid, input, 1: in_rgb, in_sof and in_mode are valid.
REQ-006 The block SHALL have port in_ready, output, 1: the block accepts the input this cycle.
REQ-007 The block SHALL have port in_sof, input, 1: start-of-frame tag for this pixel.
REQ-008 The block SHALL have port in_mode, input, 1: conversion mode, 0=LEGACY, 1=LUMA, captured per pixel.
REQ-009 The block SHALL have port out_gray, output, OUT_W: gray result.
REQ-010 The block SHALL have port out_valid, output, 1: out_gray and out_sof are valid.
REQ-011 The block SHALL have port out_ready, input, 1: the downstream consumer accepts the output.
REQ-012 The block SHALL have port out_sof, output, 1: in_sof delayed with its pixel.
REQ-013 The block SHALL have port pix_cnt, output, 24: pixels output since the last SOF.
REQ-014 The block SHALL have port sat_cnt, output, 16: saturated pixels since the last SOF.

Function
REQ-015 A transfer SHALL occur on each port when valid and ready are both 1 at a rising clk edge.
REQ-016 The pipeline SHALL have two register stages: S1 holds the sum or weighted sum, the mode and sof; S2 holds the scaled and saturated gray value and sof.
REQ-017 The latency from input transfer to out_valid SHALL be exactly 2 cycles when out_ready=1.
REQ-018 The block SHALL sustain a throughput of 1 pixel per clk.
REQ-019 A stage SHALL advance when it is empty or when the next stage advances; in_ready SHALL be !S1_valid OR S2_advance, and S2_advance SHALL be !S2_valid OR out_ready.
REQ-020 While out_valid=1 and out_ready=0, out_gray, out_sof and out_valid SHALL hold stable, and no pixel SHALL be dropped or duplicated.
REQ-021 In LEGACY mode: s = R+G+B at IN_W+2 bits; t = ((s>>3)*3)>>1; t SHALL be computed with no truncation before saturation.
REQ-022 In LUMA mode: t = (77*R + 150*G + 29*B) >> (8 + IN_W - OUT_W); intermediates SHALL be IN_W+8 bits wide.
REQ-023 Saturation SHALL be applied in both modes: out_gray = (t > 2^OUT_W-1) ? 2^OUT_W-1 : t, with sat_flag = (t > 2^OUT_W-1).
REQ-024 in_mode SHALL be captured per pixel, so a mode change affects only pixels accepted after the change.
REQ-025 Counters SHALL update only on an output transfer. When out_sof=1, pix_cnt SHALL load 1 and sat_cnt SHALL load sat_flag; otherwise pix_cnt SHALL increment by 1 and sat_cnt SHALL increment by sat_flag.
REQ-026 pix_cnt SHALL saturate at 2^24-1 and sat_cnt SHALL saturate at 2^16-1; neither SHALL wrap.
REQ-027 A simultaneous input and output transfer with pipeline full SHALL keep occupancy at 2.

Reset
REQ-028 While rst=1, all stage valids SHALL clear, out_valid SHALL be 0, out_gray SHALL be 0, out_sof SHALL be 0, pix_cnt SHALL be 0 and sat_cnt SHALL be 0.
REQ-029 in_ready SHALL be 0 during reset and 1 in the first cycle after rst deasserts.
REQ-030 Reset asserted mid-stream SHALL discard in-flight pixels; no partial output SHALL appear after reset.

Configuration
REQ-031 The macro RGB2GRAY_STATS_EN SHALL select whether the pix_cnt and sat_cnt counter logic is compiled in.
REQ-032 With RGB2GRAY_STATS_EN defined, the counters SHALL be implemented per REQ-025 and REQ-026.
REQ-033 Without RGB2GRAY_STATS_EN, pix_cnt and sat_cnt SHALL be tied to constant 0, no counter flops SHALL be present, and the ports SHALL be retained.

Verification (IN_W=10, OUT_W=8)
REQ-034 LEGACY, R=G=B=100, out_ready=1 -> out_gray=55 two cycles after the transfer, and sat_cnt is unchanged.
REQ-035 LEGACY, R=G=B=1023 -> t=574, out_gray=255, and sat_cnt increments by 1.
REQ-036 LUMA, R=G=B=1023 gives out_gray=255 with no saturation; LUMA, R=400, G=0, B=0 gives out_gray=30.
REQ-037 Stream 8 pixels with out_ready toggling 1,0,0,1 -> all 8 outputs arrive in order, values are held during stalls, and in_ready falls only while both stages are full.
REQ-038 Frame of 5 pixels, then in_sof on pixel 6 -> pix_cnt reaches 5 and then reads 1 after pixel 6 outputs; with the macro undefined, pix_cnt and sat_cnt stay 0.
REQ-039 rst asserted with 2 pixels in flight -> out_valid=0 the next cycle, no stale output appears, and the first post-reset pixel has a latency of 2.
